// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM 1:8 demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned LANES_DEF = 8;

    typedef enum logic [0:0] {
        StIdle,
        StCollect
    } state_e;

    // Even parity bit for a data word. Narrower words are zero-extended by
    // the caller, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: loads 1 on frame start, advances per accepted
// sample and wraps to 0 after the last slot of the frame.
module tdm_slot_ctr #(
    parameter  int unsigned Modulus = 8,
    localparam int unsigned W       = $clog2(Modulus)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         adv_i,
    output logic [W-1:0] slot_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next-count: frame start wins over advance.
    always_comb begin
        last_o = (cnt_q == W'(Modulus - 1));
        cnt_d  = cnt_q;
        if (load_i) begin
            cnt_d = W'(1);
        end else if (adv_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_o = cnt_q;

endmodule

// File: rtl/tdm_demux8.sv
// TDM 1:LANES demultiplexer: collects one serial sample per slot into a
// word and hands it to the consumer through a valid/ready holding register.
// Optional build macro TDM_DEMUX_PARITY_EN appends an even-parity slot.
module tdm_demux8
    import tdm_demux_pkg::*;
#(
    parameter  int unsigned LANES = LANES_DEF,
    localparam int unsigned SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [LANES-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] slot,
    output logic             overrun,
    output logic             sync_err,
    output logic             par_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FRAME = LANES + 1;
`else
    localparam int unsigned FRAME = LANES;
`endif
    localparam int unsigned CTR_W = $clog2(FRAME);

    state_e           state_q, state_d;
    logic [LANES-1:0] shift_q, shift_d;
    logic [LANES-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             sync_err_q, sync_err_d;
    logic             par_err_q, par_err_d;

    logic [CTR_W-1:0] cnt;
    logic             last_slot;
    logic             start, adv, complete;
    logic [LANES-1:0] word;
    logic             word_ok;

    tdm_slot_ctr #(
        .Modulus (FRAME)
    ) u_slot_ctr (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (start),
        .adv_i  (adv),
        .slot_o (cnt),
        .last_o (last_slot)
    );

    // Frame FSM and sample capture; frame_start always restarts at slot 0.
    always_comb begin
        start    = din_valid && frame_start;
        adv      = din_valid && !frame_start && (state_q == StCollect);
        complete = adv && last_slot;
        state_d  = state_q;
        shift_d  = shift_q;
        if (start) begin
            state_d    = StCollect;
            shift_d    = '0;
            shift_d[0] = din;
        end else if (adv) begin
            // The parity slot index matches no lane, so it writes nothing.
            for (int i = 0; i < int'(LANES); i++) begin
                if (cnt == CTR_W'(i)) begin
                    shift_d[i] = din;
                end
            end
            if (last_slot) begin
                state_d = StIdle;
            end
        end
    end

    // Output holding register and error pulses.
    always_comb begin
`ifdef TDM_DEMUX_PARITY_EN
        word    = shift_q;
        word_ok = (even_parity(32'(shift_q)) == din);
`else
        word    = shift_d;
        word_ok = 1'b1;
`endif
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        overrun_d    = 1'b0;
        sync_err_d   = start && (state_q == StCollect);
        par_err_d    = 1'b0;
        if (complete) begin
            if (!word_ok) begin
                par_err_d = 1'b1;
            end else if (!dout_valid_d) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            sync_err_q   <= sync_err_d;
            par_err_q    <= par_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = cnt[SEL_W-1:0];
    assign overrun    = overrun_q;
    assign sync_err   = sync_err_q;
    assign par_err    = par_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed scenarios plus a randomized
// run compared against a queue-based frame model.
module tb_tdm_demux8;

    localparam int LANES = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME = LANES + 1;
`else
    localparam int FRAME = LANES;
`endif

    logic       clk = 1'b0;
    logic       rst, din, din_valid, frame_start, dout_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] slot;
    logic       overrun, sync_err, par_err;

    int total = 0;
    int bad   = 0;
    int n_ovr, n_sync, n_par;

    // Reference model state
    bit         m_bits[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovr, m_sync, m_par;

    tdm_demux8 #(.LANES(LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .slot        (slot),
        .overrun     (overrun),
        .sync_err    (sync_err),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    // Frame-level model: a frame is the list of samples since frame_start.
    task automatic model_step();
        logic [7:0] w;
        bit         done, ok;
        m_ovr  = 1'b0;
        m_sync = 1'b0;
        m_par  = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_dout  = '0;
            return;
        end
        done = 0;
        ok   = 1;
        w    = '0;
        if (din_valid) begin
            if (frame_start) begin
                if (m_bits.size() > 0) m_sync = 1'b1;
                m_bits.delete();
                m_bits.push_back(din);
            end else if (m_bits.size() > 0) begin
                m_bits.push_back(din);
                if (m_bits.size() == FRAME) begin
                    done = 1;
                    for (int k = 0; k < LANES; k++) w[k] = m_bits[k];
                    if (FRAME > LANES) ok = ((^w) == m_bits[LANES]);
                    m_bits.delete();
                end
            end
        end
        if (m_valid && dout_ready) m_valid = 1'b0;
        if (done) begin
            if (!ok) m_par = 1'b1;
            else if (m_valid) m_ovr = 1'b1;
            else begin
                m_dout  = w;
                m_valid = 1'b1;
            end
        end
    endtask

    // One clock cycle: apply inputs, step the model, sample 1 ns after the edge.
    task automatic cyc(input logic d, input logic v, input logic fs, input logic r);
        din         = d;
        din_valid   = v;
        frame_start = fs;
        dout_ready  = r;
        model_step();
        @(posedge clk);
        #1;
        n_ovr  += int'(overrun);
        n_sync += int'(sync_err);
        n_par  += int'(par_err);
    endtask

    // Send slots lo..hi of a frame carrying word w (slot LANES = parity).
    task automatic send_slots(input logic [7:0] w, input int lo, input int hi,
                              input logic r, input logic flip_par);
        for (int i = lo; i <= hi; i++) begin
            cyc((i < LANES) ? w[i] : ((^w) ^ flip_par), 1'b1, i == 0, r);
        end
    endtask

    task automatic clear_counts();
        n_ovr  = 0;
        n_sync = 0;
        n_par  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        total += 4;
        if (dout !== 8'h00)       begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        if (dout_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        if (slot !== 3'd0)        begin bad++; $display("FAIL reset_slot: got %0d want 0", slot); end
        if ({overrun, sync_err, par_err} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b want 000", {overrun, sync_err, par_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_frame();
        clear_counts();
        send_slots(8'h4D, 0, FRAME - 2, 1'b1, 1'b0);
        total += 2;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL clean_early_valid: got %b want 0", dout_valid); end
        if (slot !== 3'((FRAME - 1) % LANES)) begin
            bad++; $display("FAIL clean_slot: got %0d want %0d", slot, (FRAME - 1) % LANES);
        end
        send_slots(8'h4D, FRAME - 1, FRAME - 1, 1'b1, 1'b0);
        total += 3;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL clean_valid: got %b want 1", dout_valid); end
        if (dout !== 8'h4D)      begin bad++; $display("FAIL clean_dout: got %h want 4d", dout); end
        if (slot !== 3'd0)       begin bad++; $display("FAIL clean_wrap: got %0d want 0", slot); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total += 2;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL clean_consumed: got %b want 0", dout_valid); end
        if (n_ovr + n_sync + n_par != 0) begin
            bad++; $display("FAIL clean_pulses: got %0d want 0", n_ovr + n_sync + n_par);
        end
    endtask

    task automatic test_gap();
        clear_counts();
        send_slots(8'h4D, 0, 3, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        total += 1;
        if (slot !== 3'd4) begin bad++; $display("FAIL gap_slot_hold: got %0d want 4", slot); end
        send_slots(8'h4D, 4, FRAME - 2, 1'b1, 1'b0);
        total += 1;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid: got %b want 0", dout_valid); end
        send_slots(8'h4D, FRAME - 1, FRAME - 1, 1'b1, 1'b0);
        total += 3;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL gap_valid: got %b want 1", dout_valid); end
        if (dout !== 8'h4D)      begin bad++; $display("FAIL gap_dout: got %h want 4d", dout); end
        if (n_ovr + n_sync + n_par != 0) begin
            bad++; $display("FAIL gap_pulses: got %0d want 0", n_ovr + n_sync + n_par);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        clear_counts();
        send_slots(8'hA5, 0, FRAME - 1, 1'b0, 1'b0);
        total += 2;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_first_valid: got %b want 1", dout_valid); end
        if (dout !== 8'hA5)      begin bad++; $display("FAIL ovr_first_dout: got %h want a5", dout); end
        send_slots(8'h3C, 0, FRAME - 1, 1'b0, 1'b0);
        total += 4;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        if (dout !== 8'hA5)   begin bad++; $display("FAIL ovr_dout_kept: got %h want a5", dout); end
        if (n_ovr != 1)       begin bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr); end
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", dout_valid); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total += 3;
        if (overrun !== 1'b0)    begin bad++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", dout_valid); end
        if (dout !== 8'hA5)      begin bad++; $display("FAIL ovr_dout_after: got %h want a5", dout); end
    endtask

    task automatic test_sync_err();
        clear_counts();
        send_slots(8'h12, 0, 4, 1'b1, 1'b0);
        send_slots(8'hFF, 0, 0, 1'b1, 1'b0);
        total += 2;
        if (sync_err !== 1'b1) begin bad++; $display("FAIL sync_pulse: got %b want 1", sync_err); end
        if (slot !== 3'd1)     begin bad++; $display("FAIL sync_restart_slot: got %0d want 1", slot); end
        send_slots(8'hFF, 1, FRAME - 1, 1'b1, 1'b0);
        total += 3;
        if (dout !== 8'hFF)      begin bad++; $display("FAIL sync_dout: got %h want ff", dout); end
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL sync_valid: got %b want 1", dout_valid); end
        if (n_sync != 1)         begin bad++; $display("FAIL sync_count: got %0d want 1", n_sync); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        clear_counts();
        send_slots(8'h0F, 0, 3, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        total += 3;
        if (dout !== 8'h00)      begin bad++; $display("FAIL mrst_dout: got %h want 00", dout); end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", dout_valid); end
        if (slot !== 3'd0)       begin bad++; $display("FAIL mrst_slot: got %0d want 0", slot); end
        rst = 1'b0;
        send_slots(8'hF0, 0, FRAME - 1, 1'b1, 1'b0);
        total += 2;
        if (dout !== 8'hF0)      begin bad++; $display("FAIL mrst_next_dout: got %h want f0", dout); end
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL mrst_next_valid: got %b want 1", dout_valid); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        clear_counts();
        send_slots(8'h4D, 0, FRAME - 1, 1'b1, 1'b0);
        total += 2;
        if (dout_valid !== 1'b1 || dout !== 8'h4D) begin
            bad++; $display("FAIL par_good: got %b/%h want 1/4d", dout_valid, dout);
        end
        if (par_err !== 1'b0) begin bad++; $display("FAIL par_good_err: got %b want 0", par_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_slots(8'h4D, 0, FRAME - 1, 1'b1, 1'b1);
        total += 3;
        if (par_err !== 1'b1)    begin bad++; $display("FAIL par_bad_pulse: got %b want 1", par_err); end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL par_bad_valid: got %b want 0", dout_valid); end
        if (overrun !== 1'b0)    begin bad++; $display("FAIL par_bad_ovr: got %b want 0", overrun); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            cyc(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                1'($urandom));
            total += 5;
            if (dout_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, dout_valid, m_valid);
            end
            if (dout !== m_dout) begin
                bad++; $display("FAIL rnd_dout@%0d: got %h want %h", n, dout, m_dout);
            end
            if (slot !== 3'(m_bits.size())) begin
                bad++; $display("FAIL rnd_slot@%0d: got %0d want %0d", n, slot, m_bits.size() % LANES);
            end
            if (overrun !== m_ovr || sync_err !== m_sync) begin
                bad++; $display("FAIL rnd_pulses@%0d: got %b%b want %b%b", n, overrun, sync_err,
                                m_ovr, m_sync);
            end
            if (par_err !== m_par) begin
                bad++; $display("FAIL rnd_par@%0d: got %b want %b", n, par_err, m_par);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        dout_ready  = 1'b0;
        m_valid     = 1'b0;
        m_dout      = '0;
        clear_counts();
        test_reset();
        test_clean_frame();
        test_gap();
        test_overrun();
        test_sync_err();
        test_mid_reset();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the structural 8:1 selector.
- Takes a 1-bit time-division-multiplexed stream, one lane per slot, with slot 0 flagged by frame_start.
- Steers each sample into its lane position and presents the reassembled 8-bit word through a valid/ready holding register.
- Sits between a serial link (serialiser driven by a 0..7 select counter) and parallel consumer logic.

Parameters:
- LANES, 8, number of lanes per frame; power of two, ≥2.
- SEL_W, $clog2(LANES), slot counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial sample.
- din_valid  input  1  din is valid this cycle; samples taken only when high.
- frame_start  input  1  qualified by din_valid; marks the current sample as slot 0.
- dout  output  LANES  reassembled word; bit i = sample of slot i.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
- slot  output  SEL_W  next slot index expected (debug/observe).
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame.
- par_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature); constant 0 otherwise.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, slot=0, shift/capture register=0.
  - dout=0, dout_valid=0, overrun=0, sync_err=0, par_err=0.
  - rst overrides every other input; a partial frame is discarded.
- State IDLE:
  - Samples with din_valid & !frame_start are ignored.
  - din_valid & frame_start: capture din into bit 0, slot←1, go COLLECT.
- State COLLECT:
  - din_valid=0: hold all state.
  - din_valid & !frame_start: capture din into bit[slot], slot←slot+1.
  - din_valid & frame_start: pulse sync_err, discard the partial word, capture din into bit 0, slot←1, stay COLLECT.
- Frame completion (sample accepted at slot LANES-1):
  - slot wraps to 0, go IDLE.
  - If buffer free (dout_valid=0, or dout_valid & dout_ready in the same cycle): load dout, dout_valid=1 on the next cycle. Latency is 1 cycle from the last sample edge.
  - If buffer full (dout_valid & !dout_ready): word dropped, overrun pulses, dout unchanged.
- Back-to-back frames: frame_start may be asserted in the cycle immediately after completion; no idle slot is needed.
- Output handshake:
  - dout_valid & dout_ready with no simultaneous completion: dout_valid←0, dout keeps its last value.
  - Completion and consume in the same cycle: new word loaded, dout_valid stays 1.
  - dout is stable while dout_valid=1 & dout_ready=0.
- Error pulses (overrun, sync_err, par_err) are registered, last exactly one cycle, and are independent of each other.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame is LANES+1 slots; slot LANES carries even parity over the LANES data bits.
  - The counter reaches LANES before wrapping; SEL_W grows internally to $clog2(LANES+1). The slot port shows the low SEL_W bits.
  - Completion happens on the parity slot. Mismatch: par_err pulses, word is dropped, dout_valid unaffected, overrun not raised.
- Undefined: frame is LANES slots, no parity slot, par_err tied 0.

Decomposition:
- Package tdm_demux_pkg:
  - state enum {IDLE, COLLECT}.
  - LANES_DEF=8 constant.
  - function even_parity(word).
- One sub-module, tdm_slot_ctr:
  - Wrapping slot counter with clear and load-1 on frame_start.
  - Outputs slot and last_slot flag.
  - Capture/FSM/output buffer stay in the top.

Test Plan:
- Reset then a clean frame, bits slot0..7 = 1,0,1,1,0,0,1,0, din_valid continuous, dout_ready=1 → dout=0x4D, dout_valid high exactly 1 cycle, one cycle after the slot-7 sample.
- Same frame with din_valid deasserted for 3 cycles between slot 3 and slot 4 → dout=0x4D, completion delayed 3 cycles, no error pulses.
- dout_ready=0, send two frames 0xA5 then 0x3C → dout stays 0xA5, overrun pulses once at the end of frame 2; raising dout_ready clears dout_valid.
- frame_start asserted at slot 5, followed by a full frame 0xFF → sync_err pulses once, dout=0xFF, partial word never appears.
- rst asserted at slot 4 of frame 0x0F, then frame 0xF0 → all outputs 0 after the reset edge, next dout=0xF0.
- With TDM_DEMUX_PARITY_EN: frame 0x4D, parity bit 0 → accepted. Same frame, parity bit 1 → par_err pulses, dout_valid stays 0.
